mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Sequential multiply/divide unit for the pipelined MIPS core; sits beside the combinational arithmetic unit in the EX stage.
- Owns the HI/LO register pair and executes mult, multu, div, divu, mthi, mtlo.
- Serves mfhi/mflo reads.
- Reports busy so the hazard unit can stall any later HI/LO-related instruction.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  32  operand A (rs value).
- b  input  32  operand B (rt value).
- op  input  4  operation code:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO
  - 9-15 reserved, treated as NONE.
- start  input  1  qualifies op for one cycle (issued from EX).
- busy  output  1  high while a mult/div is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- out  output  32  read data: hi when op=MFHI, lo when op=MFLO, else 0 (combinational).

Behaviour:
- Reset: synchronous, active-high; the polarity and synchronicity are fixed. On a clk edge with reset=1:
  - hi=0, lo=0, busy=0, cycle counter=0, pending result discarded.
  - Reset wins over start and over an in-flight operation.
- Accepted command: start=1, busy=0, reset=0 at edge T.
  - MULT/MULTU/DIV/DIVU: latch a, b, op and load the counter with N (MULT_CYCLES or DIV_CYCLES). busy=1 after edge T.
  - MTHI: hi<=a at edge T. MTLO: lo<=a at edge T. busy stays 0.
  - MFHI/MFLO/NONE/reserved: no state change.
- Counting: each edge while busy decrements the counter.
  - At the edge where the counter reaches 0 (edge T+N), hi/lo are written and busy drops.
  - busy is therefore high for exactly N cycles.
  - hi/lo keep their old values until that edge. No early forwarding.
- start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit must stall instead.
- Back-to-back: start at the same edge where busy falls is ignored (busy was 1). A new command is accepted on the next edge.
- MULT: signed 32x32 -> 64-bit product; hi = product[63:32], lo = product[31:0].
- MULTU: same, both operands unsigned.
- DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, remainder to hi.
- Divide by zero (b=0 for DIV/DIVU): full busy period still runs; hi/lo left unchanged at completion.
- Result computation:
  - The final value is computed from the latched operands. a/b changing during busy has no effect.
  - Any implementation is allowed (single-cycle operator latched then delayed, or iterative) provided the timing above holds.
- out is combinational from op and the current hi/lo. A MFHI during busy returns the stale value; the hazard unit guarantees it is never consumed.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy high 5 cycles; at falling edge hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged during busy.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; repeat as MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x80000000, b=3 -> lo=0x2AAAAAAA, hi=0x00000002.
- MTHI a=0x12345678, MTLO a=0x9ABCDEF0 -> hi/lo update next edge, busy stays 0; MFHI then MFLO -> out=0x12345678 then 0x9ABCDEF0.
- Then DIV b=0 -> busy 10 cycles, hi/lo unchanged.
- MULT started, MTHI a=0xDEADBEEF issued during busy -> ignored, hi is the product high word.
- Reset asserted at busy cycle 3 -> next edge busy=0, hi=lo=0, no later update.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Sequential multiply/divide unit for the EX stage of the pipelined MIPS core.
//   Owns the HI/LO register pair. It executes mult/multu/div/divu with a fixed
//   busy period, applies mthi/mtlo immediately, and serves mfhi/mflo reads
//   combinationally.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   a, b   : operands (rs, rt)
//   op     : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//            7 MFHI, 8 MFLO, 9-15 treated as NONE
//   start  : qualifies op for one cycle
//   busy   : high while a mult/div is in flight
//   hi, lo : current HI/LO registers
//   out    : hi for MFHI, lo for MFLO, otherwise 0
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [15:0] MULT_N = 16'(MULT_CYCLES);
    localparam logic [15:0] DIV_N  = 16'(DIV_CYCLES);

    logic        r_busy;
    logic [15:0] r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_sdiv_q;
    logic [31:0] w_sdiv_r;
    logic [31:0] w_udiv_q;
    logic [31:0] w_udiv_r;
    logic        w_b_zero;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_we;

    // Results are computed from the latched operands only, so changes on a/b
    // during the busy period cannot leak into the final value.
    always_comb begin
        // Low 64 bits of the product of the sign-extended operands equal the
        // signed 32x32 product.
        w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_prod_u = {32'd0, r_a} * {32'd0, r_b};

        // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case
        // of a native signed divide and gives truncation toward zero.
        w_b_zero = (r_b == 32'd0);
        w_abs_a  = r_a[31] ? (32'd0 - r_a) : r_a;
        w_abs_b  = r_b[31] ? (32'd0 - r_b) : r_b;
        w_q_mag  = w_b_zero ? 32'd0 : (w_abs_a / w_abs_b);
        w_r_mag  = w_b_zero ? 32'd0 : (w_abs_a % w_abs_b);
        w_sdiv_q = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
        w_sdiv_r = r_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
        w_udiv_q = w_b_zero ? 32'd0 : (r_a / r_b);
        w_udiv_r = w_b_zero ? 32'd0 : (r_a % r_b);

        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_we = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_we = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_we = 1'b1;
            end
            OP_DIV: begin
                w_res_hi = w_sdiv_r;
                w_res_lo = w_sdiv_q;
                w_res_we = !w_b_zero;   // divide by zero leaves HI/LO intact
            end
            OP_DIVU: begin
                w_res_hi = w_udiv_r;
                w_res_lo = w_udiv_q;
                w_res_we = !w_b_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= 16'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_op   <= 4'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else if (r_busy) begin
            // Any start while busy is dropped; the hazard unit stalls instead.
            if (r_cnt == 16'd1) begin
                r_busy <= 1'b0;
                r_cnt  <= 16'd0;
                if (w_res_we) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    r_a    <= a;
                    r_b    <= b;
                    r_op   <= op;
                    r_cnt  <= MULT_N;
                    r_busy <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    r_a    <= a;
                    r_b    <= b;
                    r_op   <= op;
                    r_cnt  <= DIV_N;
                    r_busy <= 1'b1;
                end
                OP_MTHI: r_hi <= a;
                OP_MTLO: r_lo <= a;
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign out  = (op == OP_MFHI) ? r_hi :
                  (op == OP_MFLO) ? r_lo : 32'd0;

endmodule
